cpu_control_sequencer: RTL and testbench

- Multi-cycle control unit for the 8-bit CPU.
- Fetches a 16-bit instruction through a valid-qualified handshake and decodes it.
- Steps FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and drives the ALU controls: opcode, ALUcontrol, ALUsrc, extended_immediate, and the ex_stage strobe.
- Sits between instruction memory, register file, ALU and data memory, and owns the PC.

---
 rtl/cpu_pkg.sv | 45 ++++
 rtl/instr_decoder.sv | 47 ++++
 rtl/cpu_control_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_cpu_control_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU control sequencer.
// Covers opcodes, the sequencer state encoding and instruction field positions.
package cpu_pkg;

  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_ADDI  = 3'b100;
  localparam logic [2:0] OP_LW    = 3'b010;
  localparam logic [2:0] OP_SW    = 3'b011;
  localparam logic [2:0] OP_HALT  = 3'b111;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4,
    HALT      = 3'd5
  } state_t;

  localparam int OP_MSB    = 15;
  localparam int OP_LSB    = 13;
  localparam int RD_MSB    = 12;
  localparam int RD_LSB    = 10;
  localparam int RS_MSB    = 9;
  localparam int RS_LSB    = 7;
  localparam int RT_MSB    = 6;
  localparam int RT_LSB    = 4;
  localparam int IMM_MSB   = 6;
  localparam int IMM_W     = 7;
  localparam int FUNCT_BIT = 0;

  typedef struct packed {
    logic [2:0] opcode;
    logic       alu_control;
    logic       alu_src;
    logic [2:0] rs;
    logic [2:0] rt;
    logic [2:0] rd;
    logic       is_lw;
    logic       is_sw;
    logic       is_halt;
    logic       illegal;
  } decode_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational decode of the latched instruction word into ALU controls,
// register addresses, the sign-extended immediate and an illegal-opcode flag.
module instr_decoder
  import cpu_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int DATA_W  = 8
) (
  input  logic [INSTR_W-1:0] instr,
  output decode_t            dec,
  output logic [DATA_W-1:0]  ext_imm
);

  always_comb begin
    dec        = '0;
    dec.opcode = instr[OP_MSB:OP_LSB];
    dec.rd     = instr[RD_MSB:RD_LSB];
    dec.rs     = instr[RS_MSB:RS_LSB];
    dec.rt     = instr[RT_MSB:RT_LSB];
    case (instr[OP_MSB:OP_LSB])
      OP_RTYPE: begin
        dec.alu_src     = 1'b0;
        dec.alu_control = instr[FUNCT_BIT];
      end
      OP_ADDI: begin
        dec.alu_src = 1'b1;
      end
      OP_LW: begin
        dec.alu_src = 1'b1;
        dec.is_lw   = 1'b1;
      end
      OP_SW: begin
        dec.alu_src = 1'b1;
        dec.is_sw   = 1'b1;
      end
      OP_HALT: begin
        dec.is_halt = 1'b1;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

  assign ext_imm = {{(DATA_W-IMM_W){instr[IMM_MSB]}}, instr[IMM_MSB:0]};

endmodule

// File: rtl/cpu_control_sequencer.sv
// Multi-cycle control unit: fetch handshake, decode, stage sequencing and PC ownership.
//
//   state     | meaning
//   FETCH     | request instruction, wait for imem_valid, latch word, pc+1
//   DECODE    | decode latched word, register ALU controls, flag illegal
//   EXECUTE   | single-cycle ALU strobe
//   MEMORY    | hold mem_read/mem_write until mem_ready
//   WRITEBACK | register-file write, mem_to_reg for loads
//   HALT      | terminal, left only by reset
module cpu_control_sequencer
  import cpu_pkg::*;
#(
  parameter int              INSTR_W  = 16,
  parameter int              DATA_W   = 8,
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               imem_valid,
  input  logic               mem_ready,
  output logic [PC_W-1:0]    pc,
  output logic               imem_req,
  output logic [2:0]         opcode,
  output logic               ALUcontrol,
  output logic               ALUsrc,
  output logic [DATA_W-1:0]  extended_immediate,
  output logic [2:0]         rs_addr,
  output logic [2:0]         rt_addr,
  output logic [2:0]         rd_addr,
  output logic               if_stage,
  output logic               id_stage,
  output logic               ex_stage,
  output logic               mem_stage,
  output logic               wb_stage,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic               mem_to_reg,
  output logic               halted,
  output logic               illegal_op
);

  state_t              state;
  state_t              state_next;
  logic [INSTR_W-1:0]  ir;
  decode_t             dec;
  logic [DATA_W-1:0]   dec_imm;

  logic [2:0]          opcode_r;
  logic                alu_control_r;
  logic                alu_src_r;
  logic [DATA_W-1:0]   ext_imm_r;
  logic [2:0]          rs_r;
  logic [2:0]          rt_r;
  logic [2:0]          rd_r;
  logic                lw_r;
  logic                sw_r;

  instr_decoder #(
    .INSTR_W (INSTR_W),
    .DATA_W  (DATA_W)
  ) u_instr_decoder (
    .instr   (ir),
    .dec     (dec),
    .ext_imm (dec_imm)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH: begin
        if (imem_valid) state_next = DECODE;
      end
      DECODE: begin
        if (dec.is_halt)      state_next = HALT;
        else if (dec.illegal) state_next = FETCH;
        else                  state_next = EXECUTE;
      end
      EXECUTE: begin
        state_next = (lw_r || sw_r) ? MEMORY : WRITEBACK;
      end
      MEMORY: begin
        if (mem_ready) state_next = lw_r ? WRITEBACK : FETCH;
      end
      WRITEBACK: begin
        state_next = FETCH;
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  always_comb begin
    imem_req   = 1'b0;
    if_stage   = 1'b0;
    id_stage   = 1'b0;
    ex_stage   = 1'b0;
    mem_stage  = 1'b0;
    wb_stage   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    halted     = 1'b0;
    illegal_op = 1'b0;
    case (state)
      FETCH: begin
        imem_req = 1'b1;
        if_stage = 1'b1;
      end
      DECODE: begin
        id_stage   = 1'b1;
        illegal_op = dec.illegal;
      end
      EXECUTE: begin
        ex_stage = 1'b1;
      end
      MEMORY: begin
        mem_stage = 1'b1;
        mem_read  = lw_r;
        mem_write = sw_r;
      end
      WRITEBACK: begin
        wb_stage   = 1'b1;
        reg_write  = 1'b1;
        mem_to_reg = lw_r;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        if_stage = 1'b0;
      end
    endcase
  end

  // A fetched word landing in the same cycle as reset is dropped with the rest of the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc            <= RESET_PC;
      ir            <= '0;
      opcode_r      <= '0;
      alu_control_r <= 1'b0;
      alu_src_r     <= 1'b0;
      ext_imm_r     <= '0;
      rs_r          <= '0;
      rt_r          <= '0;
      rd_r          <= '0;
      lw_r          <= 1'b0;
      sw_r          <= 1'b0;
    end else begin
      if (state == FETCH && imem_valid) begin
        ir <= imem_data;
        pc <= pc + PC_W'(1);
      end
      if (state == DECODE) begin
        opcode_r      <= dec.opcode;
        alu_control_r <= dec.alu_control;
        alu_src_r     <= dec.alu_src;
        ext_imm_r     <= dec_imm;
        rs_r          <= dec.rs;
        rt_r          <= dec.rt;
        rd_r          <= dec.rd;
        lw_r          <= dec.is_lw;
        sw_r          <= dec.is_sw;
      end
    end
  end

  assign opcode             = opcode_r;
  assign ALUcontrol         = alu_control_r;
  assign ALUsrc             = alu_src_r;
  assign extended_immediate = ext_imm_r;
  assign rs_addr            = rs_r;
  assign rt_addr            = rt_r;
  assign rd_addr            = rd_r;

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Scoreboard bench for cpu_control_sequencer: random instruction stream against
// an arithmetic reference model, plus directed halt and reset scenarios.
module tb_cpu_control_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] imem_data = '0;
  logic        imem_valid = 1'b0;
  logic        mem_ready = 1'b0;
  logic [7:0]  pc;
  logic        imem_req;
  logic [2:0]  opcode;
  logic        ALUcontrol;
  logic        ALUsrc;
  logic [7:0]  extended_immediate;
  logic [2:0]  rs_addr, rt_addr, rd_addr;
  logic        if_stage, id_stage, ex_stage, mem_stage, wb_stage;
  logic        mem_read, mem_write, reg_write, mem_to_reg;
  logic        halted, illegal_op;

  cpu_control_sequencer #(
    .INSTR_W (16),
    .DATA_W  (8),
    .PC_W    (8),
    .RESET_PC(8'd0)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .imem_data          (imem_data),
    .imem_valid         (imem_valid),
    .mem_ready          (mem_ready),
    .pc                 (pc),
    .imem_req           (imem_req),
    .opcode             (opcode),
    .ALUcontrol         (ALUcontrol),
    .ALUsrc             (ALUsrc),
    .extended_immediate (extended_immediate),
    .rs_addr            (rs_addr),
    .rt_addr            (rt_addr),
    .rd_addr            (rd_addr),
    .if_stage           (if_stage),
    .id_stage           (id_stage),
    .ex_stage           (ex_stage),
    .mem_stage          (mem_stage),
    .wb_stage           (wb_stage),
    .mem_read           (mem_read),
    .mem_write          (mem_write),
    .reg_write          (reg_write),
    .mem_to_reg         (mem_to_reg),
    .halted             (halted),
    .illegal_op         (illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    int op;
    int ctrl;
    int src;
    int imm;
    int rs;
    int rt;
    int rd;
    int pc_next;
    bit lw;
    bit sw;
    bit illegal;
    int lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  int   cur_mem_delay = 0;
  int   model_pc = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference model: fields, sign extension and latency from the ISA rules.
  function automatic exp_t model(input logic [15:0] w, input int pc_before, input int d);
    exp_t e;
    int   wi;
    int   imm7;
    wi        = int'(w);
    e.op      = wi / 8192;
    e.rd      = (wi / 1024) % 8;
    e.rs      = (wi / 128) % 8;
    e.rt      = (wi / 16) % 8;
    imm7      = wi % 128;
    e.imm     = (imm7 >= 64) ? imm7 + 128 : imm7;
    e.pc_next = (pc_before + 1) % 256;
    e.lw      = (e.op == 2);
    e.sw      = (e.op == 3);
    e.illegal = !(e.op == 0 || e.op == 2 || e.op == 3 || e.op == 4 || e.op == 7);
    e.ctrl    = (e.op == 0) ? (wi % 2) : 0;
    e.src     = (e.op == 0) ? 0 : 1;
    case (e.op)
      0, 4:    e.lat = 4;
      2:       e.lat = 5 + d;
      3:       e.lat = 4 + d;
      default: e.lat = 2;
    endcase
    return e;
  endfunction

  function automatic logic [15:0] rand_instr();
    int         k;
    logic [2:0] op;
    k = $urandom_range(0, 9);
    case (k)
      0, 1:    op = 3'b000;
      2, 3:    op = 3'b100;
      4, 5:    op = 3'b010;
      6, 7:    op = 3'b011;
      8:       op = 3'b001;
      default: op = ($urandom_range(0, 1) == 1) ? 3'b101 : 3'b110;
    endcase
    return {op, 13'($urandom)};
  endfunction

  // Data memory responder: ready on the (delay+1)th MEMORY cycle.
  int mem_cnt = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (mem_stage) begin
        mem_ready = (mem_cnt == cur_mem_delay);
        mem_cnt++;
      end else begin
        mem_ready = 1'b0;
        mem_cnt   = 0;
      end
    end
  end

  // Monitor: pops the expected record at DECODE and checks it through the instruction.
  exp_t cur;
  bit   have = 1'b0;
  int   cyc = 0;
  int   n_stage;
  always @(negedge clk) begin
    if (mon_en) begin
      n_stage = int'(if_stage) + int'(id_stage) + int'(ex_stage) + int'(mem_stage) + int'(wb_stage);
      chk("one_hot_stage", n_stage, halted ? 0 : 1);
      chk("reg_write_vs_wb", int'(reg_write), int'(wb_stage));
      if (have && (if_stage || halted)) begin
        chk("latency", cyc, cur.lat - 1);
        have = 1'b0;
      end
      if (id_stage) begin
        chk("sb_nonempty", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          cur  = exp_q.pop_front();
          have = 1'b1;
          cyc  = 1;
          chk("illegal_op", int'(illegal_op), int'(cur.illegal));
        end
      end else begin
        chk("illegal_idle", int'(illegal_op), 0);
        if (have) cyc++;
      end
      if (ex_stage && have) begin
        chk("opcode", int'(opcode), cur.op);
        chk("ALUcontrol", int'(ALUcontrol), cur.ctrl);
        chk("ALUsrc", int'(ALUsrc), cur.src);
        chk("ext_imm", int'(extended_immediate), cur.imm);
        chk("rs_addr", int'(rs_addr), cur.rs);
        chk("rt_addr", int'(rt_addr), cur.rt);
        chk("rd_addr", int'(rd_addr), cur.rd);
        chk("pc_after_fetch", int'(pc), cur.pc_next);
      end
      if (mem_stage && have) begin
        chk("mem_read", int'(mem_read), int'(cur.lw));
        chk("mem_write", int'(mem_write), int'(cur.sw));
      end else if (!mem_stage) begin
        chk("mem_idle", int'(mem_read | mem_write), 0);
      end
      if (wb_stage && have) begin
        chk("mem_to_reg", int'(mem_to_reg), int'(cur.lw));
      end
    end
  end

  task automatic issue(input logic [15:0] w, input int stall, input int d);
    int t;
    t = 0;
    while (!imem_req && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("imem_req_wait", int'(imem_req), 1);
    repeat (stall) begin
      chk("stall_req", int'(imem_req & if_stage), 1);
      chk("stall_pc", int'(pc), model_pc);
      @(negedge clk);
    end
    chk("fetch_pc", int'(pc), model_pc);
    cur_mem_delay = d;
    exp_q.push_back(model(w, model_pc, d));
    imem_data  = w;
    imem_valid = 1'b1;
    @(negedge clk);
    imem_valid = 1'b0;
    model_pc   = (model_pc + 1) % 256;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_pc", int'(pc), 0);
    chk("rst_if_stage", int'(if_stage), 1);
    chk("rst_opcode", int'(opcode), 0);
    chk("rst_alu", int'({ALUcontrol, ALUsrc}), 0);
    chk("rst_ext_imm", int'(extended_immediate), 0);
    chk("rst_strobes", int'({mem_read, mem_write, reg_write, mem_to_reg, halted, illegal_op}), 0);
    reset  = 1'b0;
    mon_en = 1'b1;

    issue(16'h1A51, 0, 0);
    issue(16'h807E, 0, 0);
    issue(16'h4085, 0, 3);
    issue(rand_instr(), 5, 0);
    for (int i = 0; i < 300; i++) begin
      issue(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 4));
    end

    issue(16'hE000, 0, 0);
    t = 0;
    while (!halted && t < 20) begin
      @(negedge clk);
      t++;
    end
    repeat (20) begin
      chk("halted_hold", int'(halted), 1);
      chk("halt_no_req", int'(imem_req), 0);
      chk("halt_pc", int'(pc), model_pc);
      @(negedge clk);
    end
    chk("sb_drained", exp_q.size(), 0);
    mon_en = 1'b0;

    reset      = 1'b1;
    imem_data  = 16'h1A51;
    imem_valid = 1'b1;
    repeat (2) @(negedge clk);
    imem_valid = 1'b0;
    reset      = 1'b0;
    chk("rst_halt_pc", int'(pc), 0);
    chk("rst_halt_if", int'(if_stage), 1);
    chk("rst_halt_cleared", int'(halted), 0);

    cur_mem_delay = 1000;
    imem_data     = 16'h6123;
    imem_valid    = 1'b1;
    @(negedge clk);
    imem_valid = 1'b0;
    t = 0;
    while (!mem_stage && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("sw_mem_write", int'(mem_write), 1);
    chk("sw_pc", int'(pc), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mem_write", int'(mem_write), 0);
    chk("rst_mem_if", int'(if_stage), 1);
    chk("rst_mem_pc", int'(pc), 0);
    chk("rst_mem_opcode", int'(opcode), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
